mux_lut_array: RTL and testbench

Parametrised array of independent N-input look-up tables, each built as a pipelined 2:1-mux tree whose leaves are constant table bits, so any N-input Boolean function (XOR, AND, mux, majority, ...) is selectable at run time. Table contents are loaded through a serial configuration port into a shadow buffer and committed atomically; data streams through one mux level per cycle. The block is the run-time-reconfigurable generalisation of the fixed mux-built gates in the combinational-logic section. It serves as a reusable logic-function tile.

---
 rtl/mux_lut_array.sv | 214 +++++++++++++++++++++
 tb/tb_mux_lut_array.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_lut_array.sv
// mux_lut_array: array of LANES run-time-reconfigurable N_IN-input LUTs.
// Each lane is a 2:1-mux tree with one registered level per input bit; leaves
// are bits of the active table. Tables are loaded serially into a shadow
// buffer and copied to the active table in one edge when the last bit lands.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_data  input word; bit l*N_IN+j is input j of lane l
//   out_valid/out_data result word, N_IN cycles after acceptance; bit l = lane l
//   cfg_start         begin or restart a table load
//   cfg_valid/cfg_bit serial table bit, position p -> lane p/ENTRIES, entry p%ENTRIES
//   cfg_busy          load in progress
//   cfg_done          one-cycle pulse after the new table is committed
module mux_lut_array #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [LANES*N_IN-1:0] in_data,
    output logic                  out_valid,
    output logic [LANES-1:0]      out_data,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_busy,
    output logic                  cfg_done
);
    localparam int unsigned ENTRIES  = 2 ** N_IN;
    localparam int unsigned CFG_BITS = LANES * ENTRIES;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    // Reset table: every lane computes the XOR of its inputs.
    function automatic logic [CFG_BITS-1:0] parity_tbl();
        logic [CFG_BITS-1:0] t;
        t = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                t[l*ENTRIES + e] = ^e;
            end
        end
        return t;
    endfunction

    localparam logic [CFG_BITS-1:0] PARITY_TBL = parity_tbl();

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shd_q, shd_d;
    logic [CFG_BITS-1:0] act_q, act_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic [CNT_W-1:0]    wr_pos;

    // Config FSM: a restart rewinds the write position to 0 in the same cycle,
    // so a bit presented alongside cfg_start lands at position 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        act_d   = act_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_pos  = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    wr_pos  = '0;
                    wr_en   = cfg_valid;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    cnt_d  = '0;
                    wr_pos = '0;
                end
                wr_en = cfg_valid;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_en) begin
            for (int p = 0; p < CFG_BITS; p++) begin
                if (wr_pos == CNT_W'(p)) begin
                    shd_d[p] = cfg_bit;
                end
            end
            cnt_d = wr_pos + CNT_W'(1);
            // Last bit: commit the shadow, including this bit, on the same edge.
            if (wr_pos == CNT_W'(CFG_BITS - 1)) begin
                act_d   = shd_d;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shd_q   <= PARITY_TBL;
            act_q   <= PARITY_TBL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shd_q   <= shd_d;
            act_q   <= act_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cfg_busy = busy_q;
    assign cfg_done = done_q;

    // Mux-tree pipeline. Stage k halves the candidate set using input bit k;
    // the not-yet-consumed input bits ride along in hi_q.
    for (genvar k = 0; k < N_IN; k++) begin : g_stg
        localparam int unsigned W = ENTRIES >> (k + 1);

        logic                      vld_in;
        logic [LANES-1:0]          sel;
        logic [LANES-1:0][2*W-1:0] src;
        logic [LANES-1:0][W-1:0]   dat_d;
        logic                      vld_q;
        logic [LANES-1:0][W-1:0]   dat_q;

        if (k == 0) begin : g_head
            // Only the first stage reads the active table.
            always_comb begin
                vld_in = in_valid;
                for (int l = 0; l < LANES; l++) begin
                    sel[l] = in_data[l*N_IN];
                    src[l] = act_q[l*ENTRIES +: ENTRIES];
                end
            end
        end else begin : g_body
            always_comb begin
                vld_in = g_stg[k-1].vld_q;
                for (int l = 0; l < LANES; l++) begin
                    sel[l] = g_stg[k-1].g_hi.hi_q[l][0];
                    src[l] = g_stg[k-1].dat_q[l];
                end
            end
        end

        always_comb begin
            for (int l = 0; l < LANES; l++) begin
                for (int m = 0; m < W; m++) begin
                    dat_d[l][m] = sel[l] ? src[l][2*m + 1] : src[l][2*m];
                end
            end
        end

        // Data only advances with a valid word, so the final stage holds its value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_in;
                if (vld_in) begin
                    dat_q <= dat_d;
                end
            end
        end

        if (k + 1 < N_IN) begin : g_hi
            localparam int unsigned HW = N_IN - 1 - k;

            logic [LANES-1:0][HW-1:0] hi_d;
            logic [LANES-1:0][HW-1:0] hi_q;

            if (k == 0) begin : g_from_in
                always_comb begin
                    for (int l = 0; l < LANES; l++) begin
                        hi_d[l] = in_data[l*N_IN + 1 +: HW];
                    end
                end
            end else begin : g_from_prev
                always_comb begin
                    for (int l = 0; l < LANES; l++) begin
                        hi_d[l] = g_stg[k-1].g_hi.hi_q[l][HW:1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hi_q <= '0;
                end else if (vld_in) begin
                    hi_q <= hi_d;
                end
            end
        end
    end

    assign out_valid = g_stg[N_IN-1].vld_q;
    assign out_data  = g_stg[N_IN-1].dat_q;

endmodule

// File: tb/tb_mux_lut_array.sv
// tb_mux_lut_array: drives three mux_lut_array instances (N_IN/LANES = 2/4,
// 1/1, 4/2) from one shared stimulus stream and compares every cycle against
// a table-lookup reference model kept per instance.
module tb_mux_lut_array;
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start, cfg_valid, cfg_bit, in_valid;
    logic [7:0] in_data;

    logic       ov0, ov1, ov2;
    logic [3:0] od0;
    logic [0:0] od1;
    logic [1:0] od2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    always #5 clk = ~clk;

    mux_lut_array #(.N_IN(2), .LANES(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov0), .out_data(od0), .cfg_start(cfg_start),
        .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(busy0), .cfg_done(done0));

    mux_lut_array #(.N_IN(1), .LANES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[0:0]),
        .out_valid(ov1), .out_data(od1), .cfg_start(cfg_start),
        .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(busy1), .cfg_done(done1));

    mux_lut_array #(.N_IN(4), .LANES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov2), .out_data(od2), .cfg_start(cfg_start),
        .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(busy2), .cfg_done(done2));

    typedef struct {
        int         due;
        logic [7:0] w;
    } exp_t;

    int          checks;
    int          errs;
    int          cyc;
    logic [31:0] act_m   [NDUT];
    logic [31:0] shd_m   [NDUT];
    bit          load_m  [NDUT];
    int          pos_m   [NDUT];
    bit          done_m  [NDUT];
    logic [7:0]  last_m  [NDUT];
    exp_t        exp_q   [NDUT][$];
    logic [7:0]  got_q   [NDUT][$];
    int          done_cnt[NDUT];
    logic [15:0] tbl_a;
    logic [7:0]  s2_exp  [8];

    function automatic int nin(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int lanes(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reset: every table entry is the XOR of its index bits.
    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            int e_n;
            e_n = 1 << nin(d);
            act_m[d] = '0;
            for (int l = 0; l < lanes(d); l++) begin
                for (int e = 0; e < e_n; e++) begin
                    act_m[d][l*e_n + e] = 1'($countones(e) % 2);
                end
            end
            shd_m[d]  = act_m[d];
            load_m[d] = 1'b0;
            pos_m[d]  = 0;
            done_m[d] = 1'b0;
            last_m[d] = '0;
            exp_q[d].delete();
        end
    endtask

    // One clock edge of the reference: lookup with the table as it stood
    // before this edge, then apply the config bit.
    task automatic model_edge(input bit s, input bit cv, input bit cb,
                              input bit iv, input logic [7:0] id);
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            int n, e_n, cb_n;
            n    = nin(d);
            e_n  = 1 << n;
            cb_n = lanes(d) * e_n;
            if (iv) begin
                exp_t x;
                x.w   = '0;
                x.due = cyc + n - 1;
                for (int l = 0; l < lanes(d); l++) begin
                    int idx;
                    idx    = (int'(id) >> (l*n)) & (e_n - 1);
                    x.w[l] = act_m[d][l*e_n + idx];
                end
                exp_q[d].push_back(x);
            end
            done_m[d] = 1'b0;
            if (s) begin
                load_m[d] = 1'b1;
                pos_m[d]  = 0;
            end
            if (load_m[d] && cv) begin
                shd_m[d][pos_m[d]] = cb;
                pos_m[d]++;
                if (pos_m[d] == cb_n) begin
                    act_m[d]  = shd_m[d];
                    load_m[d] = 1'b0;
                    done_m[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < NDUT; d++) begin
            logic       o_v, o_b, o_dn, e_v;
            logic [7:0] o_d;
            case (d)
                0:       begin o_v = ov0; o_d = {4'b0, od0}; o_b = busy0; o_dn = done0; end
                1:       begin o_v = ov1; o_d = {7'b0, od1}; o_b = busy1; o_dn = done1; end
                default: begin o_v = ov2; o_d = {6'b0, od2}; o_b = busy2; o_dn = done2; end
            endcase
            e_v = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
            chk($sformatf("d%0d out_valid", d), 32'(o_v), 32'(e_v));
            if (e_v) begin
                exp_t x;
                x = exp_q[d].pop_front();
                last_m[d] = x.w;
            end
            chk($sformatf("d%0d out_data", d), 32'(o_d), 32'(last_m[d]));
            chk($sformatf("d%0d cfg_busy", d), 32'(o_b), 32'(load_m[d]));
            chk($sformatf("d%0d cfg_done", d), 32'(o_dn), 32'(done_m[d]));
            if (o_v === 1'b1) got_q[d].push_back(o_d);
            if (o_dn === 1'b1) done_cnt[d]++;
        end
    endtask

    task automatic step(input bit s, input bit cv, input bit cb,
                        input bit iv, input logic [7:0] id);
        cfg_start = s;
        cfg_valid = cv;
        cfg_bit   = cb;
        in_valid  = iv;
        in_data   = id;
        @(posedge clk);
        model_edge(s, cv, cb, iv, id);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_logs();
        for (int d = 0; d < NDUT; d++) begin
            got_q[d].delete();
            done_cnt[d] = 0;
        end
    endtask

    // Asynchronous reset in the middle of the low clock phase.
    task automatic pulse_reset(input int n);
        #2 rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        #1 model_reset();
        compare_all();
        for (int i = 0; i < n; i++) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish by 400us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errs   = 0;
        cyc    = 0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        model_reset();
        clear_logs();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Parity tables straight out of reset.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'b11_10_01_00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'b00_00_00_01);
        idle(5);
        chk("s1 d0 count", 32'(got_q[0].size()), 32'd2);
        chk("s1 d0 parity", 32'(got_q[0][0]), 32'h6);
        chk("s1 d1 parity0", 32'(got_q[1][0]), 32'h0);
        chk("s1 d1 parity1", 32'(got_q[1][1]), 32'h1);
        chk("s1 d2 parity", 32'(got_q[2][0]), 32'h3);

        // Load AND/OR/NOR/XNOR while streaming idx 3 across the commit edge.
        tbl_a  = 16'b1001_0001_1110_1000;
        s2_exp = '{8'h0, 8'h0, 8'h0, 8'hB, 8'hC, 8'h2, 8'h2, 8'hB};
        clear_logs();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int p = 0; p < 16; p++) step(1'b0, 1'b1, tbl_a[p], (p >= 13), 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, {4{2'(i)}});
        idle(6);
        chk("s2 d0 count", 32'(got_q[0].size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("s2 d0 word%0d", i), 32'(got_q[0][i]), 32'(s2_exp[i]));
        chk("s2 d0 done pulses", 32'(done_cnt[0]), 32'd1);
        chk("s2 d0 busy", 32'(busy0), 32'd0);
        chk("s2 d2 busy mid", 32'(busy2), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 8'h00);
        idle(2);
        chk("s6 d2 done pulses", 32'(done_cnt[2]), 32'd1);

        // Abort after five ones, then an all-zero load with gaps.
        clear_logs();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            idle(1);
        end
        chk("s4 d0 done pulses", 32'(done_cnt[0]), 32'd1);
        chk("s4 d1 done pulses", 32'(done_cnt[1]), 32'd2);
        chk("s4 d2 done pulses", 32'(done_cnt[2]), 32'd1);
        clear_logs();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
        idle(6);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("s4 d%0d count", d), 32'(got_q[d].size()), 32'd8);
            foreach (got_q[d][i]) chk($sformatf("s4 d%0d zero%0d", d, i), 32'(got_q[d][i]), 32'd0);
        end

        // cfg_valid while idle is ignored.
        clear_logs();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom));
        idle(6);
        chk("s5 d0 no done", 32'(done_cnt[0]), 32'd0);
        chk("s5 d2 no done", 32'(done_cnt[2]), 32'd0);
        foreach (got_q[0][i]) chk($sformatf("s5 d0 zero%0d", i), 32'(got_q[0][i]), 32'd0);

        // Reset mid-load with words in flight.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom));
        pulse_reset(3);
        chk("s5 busy after reset", 32'({busy0, busy1, busy2}), 32'd0);
        clear_logs();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        idle(6);
        chk("s5 d0 count", 32'(got_q[0].size()), 32'd2);
        chk("s5 d0 parity ff", 32'(got_q[0][0]), 32'h0);
        chk("s5 d0 parity 55", 32'(got_q[0][1]), 32'hF);
        chk("s5 d1 parity 55", 32'(got_q[1][1]), 32'h1);
        chk("s5 d2 parity 55", 32'(got_q[2][1]), 32'h0);

        // Randomised traffic with occasional restarts and one reset.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(49) == 0), ($urandom_range(2) != 0), 1'($urandom_range(1)),
                 ($urandom_range(3) != 0), 8'($urandom));
            if (i == 700) pulse_reset(2);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
